// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: scan FSM states, key codes
// ({row_idx, col_idx}) and the row/column to digit lookup helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } kp_state_e;

    // Key codes by physical position {row, col}
    localparam logic [3:0] KEY_1    = 4'h0;
    localparam logic [3:0] KEY_2    = 4'h1;
    localparam logic [3:0] KEY_3    = 4'h2;
    localparam logic [3:0] KEY_A    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_B    = 4'h7;
    localparam logic [3:0] KEY_7    = 4'h8;
    localparam logic [3:0] KEY_8    = 4'h9;
    localparam logic [3:0] KEY_9    = 4'hA;
    localparam logic [3:0] KEY_C    = 4'hB;
    localparam logic [3:0] KEY_STAR = 4'hC;
    localparam logic [3:0] KEY_0    = 4'hD;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_D    = 4'hF;

    localparam int unsigned NUM_NIBBLES = 8;

    // True for the ten decimal keys
    function automatic logic key_is_digit(input logic [3:0] code);
        return ((code[3:2] != 2'd3) && (code[1:0] != 2'd3)) || (code == KEY_0);
    endfunction

    // Decimal value of a digit key; rows 0..2 hold 1..9 left to right
    function automatic logic [3:0] key_digit(input logic [3:0] code);
        if (code == KEY_0) begin
            return 4'd0;
        end
        return ({2'b00, code[3:2]} * 4'd3) + {2'b00, code[1:0]} + 4'd1;
    endfunction

    // Exactly one active-low row asserted
    function automatic logic row_single(input logic [3:0] rows);
        logic [3:0] low;
        low = ~rows;
        return (low != 4'h0) && ((low & (low - 4'd1)) == 4'h0);
    endfunction

    // Index of the single asserted active-low row
    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        case (~rows)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/bcd_to_binary.sv
// Multi-cycle packed-BCD (8 digits) to 32-bit binary converter.
// One digit per clock, most significant nibble first: acc = acc*10 + nibble.
// busy is high for the 8 iteration cycles; done pulses with the result.
module bcd_to_binary
    import keypad_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bcd,
    output logic        busy,
    output logic        done,
    output logic [31:0] bin
);

    logic [31:0] sr_q;
    logic [31:0] acc_q;
    logic [31:0] bin_q;
    logic [2:0]  iter_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] acc_next;

    assign acc_next = (acc_q * 32'd10) + {28'h0, sr_q[31:28]};

    // Iteration engine: load snapshot on start, then consume one nibble per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            acc_q  <= '0;
            bin_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                acc_q  <= acc_next;
                sr_q   <= {sr_q[27:0], 4'h0};
                iter_q <= iter_q + 3'd1;
                if (iter_q == 3'(NUM_NIBBLES - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    bin_q  <= acc_next;
                end
            end else if (start) begin
                busy_q <= 1'b1;
                sr_q   <= bcd;
                acc_q  <= '0;
                iter_q <= '0;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bin  = bin_q;

endmodule

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce and 8-digit decimal entry buffer.
// '#' converts the entered digits to binary through bcd_to_binary.
// Optional build macro: KEYPAD_AUTOREPEAT_EN (digit keys auto-repeat while held).
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned MAX_DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [31:0] bcd_digits,
    output logic [3:0]  digit_cnt,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [31:0] num_out,
    output logic        num_valid,
    output logic        busy
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV + 1);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

    kp_state_e          state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic [1:0]         col_q, col_d;
    logic [1:0]         row_q, row_d;
    logic [3:0]         pat_q, pat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic               accept;
    logic               kv_q;
    logic [3:0]         kc_q;
    logic [31:0]        bcd_q, bcd_d;
    logic [3:0]         dcnt_q, dcnt_d;
    logic               conv_start;
    logic               conv_busy;
    logic               conv_done;
    logic [31:0]        conv_bin;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [6:0]         rep_q, rep_d;
    logic               rep_first_q, rep_first_d;
`endif

    assign tick = (div_q == DIV_W'(SCAN_DIV - 1));

    // Scan tick divider: one tick per column period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Scan/debounce FSM next state; rows only looked at on a tick
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        accept  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_single(row_in)) begin
                        row_d = row_index(row_in);
                        pat_d = row_in;
                        cnt_d = CNT_W'(1);
                        if (DEBOUNCE_CNT <= 1) begin
                            accept  = 1'b1;
                            rcnt_d  = '0;
                            state_d = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d       = '0;
                            rep_first_d = 1'b1;
`endif
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_in == pat_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q >= CNT_W'(DEBOUNCE_CNT - 1)) begin
                            accept  = 1'b1;
                            rcnt_d  = '0;
                            state_d = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d       = '0;
                            rep_first_d = 1'b1;
`endif
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (row_in == 4'hF) begin
                        if (rcnt_q >= CNT_W'(DEBOUNCE_CNT - 1)) begin
                            rcnt_d  = '0;
                            state_d = ST_SCAN;
                        end else begin
                            rcnt_d = rcnt_q + CNT_W'(1);
                        end
                    end else begin
                        rcnt_d = '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if ((row_in == pat_q) && key_is_digit(kc_q)) begin
                        if (rep_q >= (rep_first_q ? 7'd63 : 7'd15)) begin
                            accept      = 1'b1;
                            rep_d       = '0;
                            rep_first_d = 1'b0;
                        end else begin
                            rep_d = rep_q + 7'd1;
                        end
                    end else begin
                        rep_d       = '0;
                        rep_first_d = 1'b1;
                    end
`endif
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    // Scan/debounce FSM state and accepted-key registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SCAN;
            col_q   <= '0;
            row_q   <= '0;
            pat_q   <= '1;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            kv_q    <= 1'b0;
            kc_q    <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            kv_q    <= accept;
            if (accept) begin
                kc_q <= {row_d, col_d};
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    // Key action applied the clock after key_valid, so '#' snapshots the settled buffer
    always_comb begin
        bcd_d      = bcd_q;
        dcnt_d     = dcnt_q;
        conv_start = 1'b0;
        if (kv_q) begin
            if (key_is_digit(kc_q)) begin
                if (dcnt_q < 4'(MAX_DIGITS)) begin
                    bcd_d  = {bcd_q[27:0], key_digit(kc_q)};
                    dcnt_d = dcnt_q + 4'd1;
                end
            end else begin
                case (kc_q)
                    KEY_STAR: begin
                        bcd_d  = '0;
                        dcnt_d = '0;
                    end
                    KEY_B: begin
                        if (dcnt_q != 4'd0) begin
                            bcd_d  = {4'h0, bcd_q[31:4]};
                            dcnt_d = dcnt_q - 4'd1;
                        end
                    end
                    KEY_HASH: begin
                        if (!conv_busy) begin
                            conv_start = 1'b1;
                            bcd_d      = '0;
                            dcnt_d     = '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Digit entry buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            dcnt_q <= '0;
        end else begin
            bcd_q  <= bcd_d;
            dcnt_q <= dcnt_d;
        end
    end

    bcd_to_binary u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bcd   (bcd_q),
        .busy  (conv_busy),
        .done  (conv_done),
        .bin   (conv_bin)
    );

    assign col_out    = ~(4'b0001 << col_q);
    assign bcd_digits = bcd_q;
    assign digit_cnt  = dcnt_q;
    assign key_code   = kc_q;
    assign key_valid  = kv_q;
    assign num_out    = conv_bin;
    assign num_valid  = conv_done;
    assign busy       = conv_busy;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural 4x4 keypad matrix.
module tb_keypad_entry;
    import keypad_pkg::*;

    localparam int unsigned SDIV = 4;
    localparam int unsigned DEB  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [31:0] bcd_digits;
    logic [3:0]  digit_cnt;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [31:0] num_out;
    logic        num_valid;
    logic        busy;

    logic [15:0] pressed = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int kv_cnt = 0;
    int nv_cnt = 0;
    int nv_cyc = 0;
    logic [31:0] nv_val = '0;

    keypad_entry #(.SCAN_DIV(SDIV), .DEBOUNCE_CNT(DEB), .MAX_DIGITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_in     (row_in),
        .col_out    (col_out),
        .bcd_digits (bcd_digits),
        .digit_cnt  (digit_cnt),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .num_out    (num_out),
        .num_valid  (num_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (num_valid) begin
            nv_cnt++;
            nv_cyc = cyc;
            nv_val = num_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Press a key, wait for its key_valid, release and let the release debounce finish
    task automatic press(input logic [3:0] code, output int kv_at);
        logic ok;
        ok = 1'b0;
        kv_at = 0;
        pressed = 16'h1 << code;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                kv_at = cyc;
                break;
            end
        end
        chk("key_valid_seen", 32'(ok), 32'd1);
        if (ok && code == KEY_HASH) begin
            @(negedge clk);
            chk("busy_after_hash", 32'(busy), 32'd1);
        end
        pressed = '0;
        repeat (40) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [31:0] bcd;
        logic [3:0]  cnt;
        logic        conv;
        logic [31:0] num;
    } vec_t;

    vec_t vecs [18];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int kv_at;
        int kv0;
        int nv0;
        logic [31:0] exp_bcd;
        logic [3:0]  seen;
        logic        ok;

        vecs[0]  = '{KEY_1,    32'h1,    4'd1, 1'b0, 32'd0};
        vecs[1]  = '{KEY_2,    32'h12,   4'd2, 1'b0, 32'd0};
        vecs[2]  = '{KEY_3,    32'h123,  4'd3, 1'b0, 32'd0};
        vecs[3]  = '{KEY_4,    32'h1234, 4'd4, 1'b0, 32'd0};
        vecs[4]  = '{KEY_HASH, 32'h0,    4'd0, 1'b1, 32'd1234};
        vecs[5]  = '{KEY_5,    32'h5,    4'd1, 1'b0, 32'd0};
        vecs[6]  = '{KEY_6,    32'h56,   4'd2, 1'b0, 32'd0};
        vecs[7]  = '{KEY_B,    32'h5,    4'd1, 1'b0, 32'd0};
        vecs[8]  = '{KEY_7,    32'h57,   4'd2, 1'b0, 32'd0};
        vecs[9]  = '{KEY_HASH, 32'h0,    4'd0, 1'b1, 32'd57};
        vecs[10] = '{KEY_1,    32'h1,    4'd1, 1'b0, 32'd0};
        vecs[11] = '{KEY_2,    32'h12,   4'd2, 1'b0, 32'd0};
        vecs[12] = '{KEY_STAR, 32'h0,    4'd0, 1'b0, 32'd0};
        vecs[13] = '{KEY_A,    32'h0,    4'd0, 1'b0, 32'd0};
        vecs[14] = '{KEY_0,    32'h0,    4'd1, 1'b0, 32'd0};
        vecs[15] = '{KEY_B,    32'h0,    4'd0, 1'b0, 32'd0};
        vecs[16] = '{KEY_B,    32'h0,    4'd0, 1'b0, 32'd0};
        vecs[17] = '{KEY_HASH, 32'h0,    4'd0, 1'b1, 32'd0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_col_out",   32'(col_out),    32'hE);
        chk("rst_bcd",       bcd_digits,      32'h0);
        chk("rst_digit_cnt", 32'(digit_cnt),  32'h0);
        chk("rst_key_valid", 32'(key_valid),  32'h0);
        chk("rst_num_out",   num_out,         32'h0);
        chk("rst_busy",      32'(busy),       32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven key sequences
        for (int i = 0; i < 18; i++) begin
            kv0 = kv_cnt;
            nv0 = nv_cnt;
            press(vecs[i].code, kv_at);
            chk("kv_one_pulse", 32'(kv_cnt - kv0), 32'd1);
            chk("key_code", 32'(key_code), 32'(vecs[i].code));
            chk("bcd_digits", bcd_digits, vecs[i].bcd);
            chk("digit_cnt", 32'(digit_cnt), 32'(vecs[i].cnt));
            if (vecs[i].conv) begin
                chk("nv_one_pulse", 32'(nv_cnt - nv0), 32'd1);
                chk("num_out", nv_val, vecs[i].num);
                chk("nv_latency", 32'(nv_cyc - kv_at), 32'd9);
                chk("busy_done", 32'(busy), 32'd0);
            end
        end

        // Nine '9' presses: capacity stops at 8 digits
        exp_bcd = '0;
        for (int i = 0; i < 9; i++) begin
            kv0 = kv_cnt;
            press(KEY_9, kv_at);
            if (i < 8) exp_bcd = {exp_bcd[27:0], 4'h9};
            chk("nine_kv", 32'(kv_cnt - kv0), 32'd1);
            chk("nine_bcd", bcd_digits, exp_bcd);
            chk("nine_cnt", 32'(digit_cnt), (i < 8) ? 32'(i + 1) : 32'd8);
        end
        nv0 = nv_cnt;
        press(KEY_HASH, kv_at);
        chk("nine_nv", 32'(nv_cnt - nv0), 32'd1);
        chk("nine_num", nv_val, 32'd99999999);
        chk("nine_clear", 32'(digit_cnt), 32'd0);

        // Bouncing '5': alternate samples, then stable low
        kv0 = kv_cnt;
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? (16'h1 << KEY_5) : 16'h0;
            repeat (SDIV) @(negedge clk);
        end
        chk("bounce_no_kv", 32'(kv_cnt - kv0), 32'd0);
        press(KEY_5, kv_at);
        chk("bounce_one_kv", 32'(kv_cnt - kv0), 32'd1);
        chk("bounce_bcd", bcd_digits, 32'h5);
        chk("bounce_cnt", 32'(digit_cnt), 32'd1);

        // Two rows low in column 0: ignored, scan keeps rotating
        kv0 = kv_cnt;
        seen = '0;
        pressed = (16'h1 << KEY_1) | (16'h1 << KEY_4);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            seen = seen | ~col_out;
        end
        pressed = '0;
        repeat (20) @(negedge clk);
        chk("multi_no_kv", 32'(kv_cnt - kv0), 32'd0);
        chk("multi_rotate", 32'(seen), 32'hF);

        // Reset three clocks into a conversion
        press(KEY_1, kv_at);
        press(KEY_2, kv_at);
        nv0 = nv_cnt;
        pressed = 16'h1 << KEY_HASH;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_hash_kv", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        pressed = '0;
        #1;
        chk("mid_col_out",   32'(col_out),   32'hE);
        chk("mid_bcd",       bcd_digits,     32'h0);
        chk("mid_digit_cnt", 32'(digit_cnt), 32'h0);
        chk("mid_key_code",  32'(key_code),  32'h0);
        chk("mid_num_out",   num_out,        32'h0);
        chk("mid_busy",      32'(busy),      32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_no_nv", 32'(nv_cnt - nv0), 32'd0);
        chk("mid_num_after", num_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
